uart_rx_param: RTL

- Parametrised UART receiver for the DDS control path; successor to the fixed 8N1 115200 receiver.
- Supports configurable data width, parity mode and stop-bit count, with parity/framing/overrun error reporting.
- Output side is a valid/ready handshake so downstream command parsers can stall without losing the flag.
- Sits between the board RX pin and the command decoder.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states, default bit timings.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // 100 MHz system clock
    localparam int unsigned CLKS_115200 = 868;
    localparam int unsigned CLKS_921600 = 108;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high serial line, plus falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rs,
    output logic fall
);

    logic s1_q, rs_q, rs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
        end else begin
            s1_q      <= rx;
            rs_q      <= s1_q;
            rs_prev_q <= rs_q;
        end
    end

    assign rs   = rs_q;
    assign fall = rs_prev_q & ~rs_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity/framing/overrun flags and a valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_115200,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic rs, fall, bit_val, sample, parity_bad;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .rs   (rs),
        .fall (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] MID_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DECIDE = CW'(CLKS_PER_BIT / 2 + 1);

    logic [CW-1:0] cnt_q;
    logic [1:0]    vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (cnt_q == MID_M1) vote_d[0] = rs;
        if (cnt_q == MID)    vote_d[1] = rs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vote_q <= 2'b11;
        else        vote_q <= vote_d;
    end

    assign bit_val = maj3(vote_q[0], vote_q[1], rs);
`else
    localparam logic [CW-1:0] DECIDE = MID;

    logic [CW-1:0] cnt_q;

    assign bit_val = rs;
`endif

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic                 acc_par_q, acc_par_d, acc_ferr_q, acc_ferr_d;
    logic                 rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;

    // Counter runs freely from the start edge, so every bit is sampled at the same phase.
    assign sample = (cnt_q == DECIDE);

    always_comb begin
        parity_bad = 1'b0;
        if (PARITY == PARITY_ODD)       parity_bad = ~acc_par_q;
        else if (PARITY == PARITY_EVEN) parity_bad = acc_par_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        acc_par_d    = acc_par_q;
        acc_ferr_d   = acc_ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (sample) begin
                    if (bit_val) begin
                        state_d = StIdle;
                    end else begin
                        state_d    = StData;
                        bit_d      = '0;
                        acc_par_d  = 1'b0;
                        acc_ferr_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (sample) begin
                    shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                    acc_par_d = acc_par_q ^ bit_val;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (sample) begin
                    acc_par_d = acc_par_q ^ bit_val;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (sample) begin
                    if (!bit_val) acc_ferr_d = 1'b1;
                    if (bit_q == 4'(STOP_BITS - 1)) state_d = StDone;
                    else                            bit_d   = bit_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!rx_valid_q || rx_ready) begin
                    rx_data_d    = shift_q;
                    rx_valid_d   = 1'b1;
                    parity_err_d = parity_bad;
                    frame_err_d  = acc_ferr_q;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            acc_par_q    <= 1'b0;
            acc_ferr_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            acc_par_q    <= acc_par_d;
            acc_ferr_q   <= acc_ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != StIdle);

endmodule
